// File: rtl/div_pkg.sv
// Shared definitions for the longdivider sequencer: state encoding,
// default operand width and the divide-by-zero quotient.
package div_pkg;

    localparam int N_DEFAULT = 8;

    // Wide enough for any supported N; sliced to N where used.
    localparam logic [63:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        RESULT = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Operand/result handshake channels plus the longdivider core pins.
// slave = sequencer view, master = environment (upstream, downstream, core).
interface div_sequencer_if #(
    parameter int N = div_pkg::N_DEFAULT
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_q;
    logic [N-1:0] out_r;
    logic         out_dbz;
    logic         div_s;
    logic         div_la;
    logic         div_eb;
    logic [N-1:0] div_a;
    logic [N-1:0] div_b;
    logic [N-1:0] div_q;
    logic [N-1:0] div_r;
    logic         div_done;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, div_q, div_r, div_done,
        output in_ready, out_valid, out_q, out_r, out_dbz,
               div_s, div_la, div_eb, div_a, div_b
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, div_q, div_r, div_done,
        input  in_ready, out_valid, out_q, out_r, out_dbz,
               div_s, div_la, div_eb, div_a, div_b
    );

endinterface

// File: rtl/div_hold_reg.sv
// N-bit load-enabled register, asynchronous active-low clear.
module div_hold_reg #(
    parameter int N = div_pkg::N_DEFAULT
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)  q <= '0;
        else if (en)  q <= d;
    end

endmodule

// File: rtl/div_sequencer.sv
// Valid/ready front-end and result collector for the longdivider core.
// Optional divide-by-zero short-circuit: define DIV_SEQ_DBZ_CHECK_EN.
module div_sequencer
    import div_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           Clock,
    input  logic           Resetn,
    div_sequencer_if.slave bus
);

    div_state_e   state, state_nxt;
    logic         accept;
    logic         dbz_accept;
    logic         res_en;
    logic [N-1:0] res_q_d;
    logic [N-1:0] res_r_d;

    assign accept = (state == IDLE) && bus.in_valid;

`ifdef DIV_SEQ_DBZ_CHECK_EN
    assign dbz_accept = accept && (bus.in_b == '0);
`else
    assign dbz_accept = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (bus.in_valid) state_nxt = dbz_accept ? RESULT : LOAD;
            LOAD:   state_nxt = RUN;
            RUN:    if (bus.div_done) state_nxt = RESULT;
            // Holding until Done drops keeps the core from seeing the next LOAD early.
            RESULT: if (bus.out_ready && !bus.div_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.div_la    = 1'b0;
        bus.div_eb    = 1'b0;
        bus.div_s     = 1'b0;
        case (state)
            IDLE:    bus.in_ready  = 1'b1;
            LOAD:    begin
                bus.div_la = 1'b1;
                bus.div_eb = 1'b1;
            end
            RUN:     bus.div_s     = 1'b1;
            RESULT:  bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    div_hold_reg #(.N(N)) u_hold_a (
        .Clock (Clock), .Resetn (Resetn), .en (accept), .d (bus.in_a), .q (bus.div_a)
    );

    div_hold_reg #(.N(N)) u_hold_b (
        .Clock (Clock), .Resetn (Resetn), .en (accept), .d (bus.in_b), .q (bus.div_b)
    );

    assign res_en  = ((state == RUN) && bus.div_done) || dbz_accept;
    assign res_q_d = dbz_accept ? DBZ_QUOTIENT[N-1:0] : bus.div_q;
    assign res_r_d = dbz_accept ? bus.in_a            : bus.div_r;

    div_hold_reg #(.N(N)) u_res_q (
        .Clock (Clock), .Resetn (Resetn), .en (res_en), .d (res_q_d), .q (bus.out_q)
    );

    div_hold_reg #(.N(N)) u_res_r (
        .Clock (Clock), .Resetn (Resetn), .en (res_en), .d (res_r_d), .q (bus.out_r)
    );

`ifdef DIV_SEQ_DBZ_CHECK_EN
    logic dbz_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)     dbz_q <= 1'b0;
        else if (res_en) dbz_q <= dbz_accept;
    end

    assign bus.out_dbz = dbz_q;
`else
    assign bus.out_dbz = 1'b0;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: behavioural longdivider core, queue scoreboard,
// vector table, timing/backpressure/reset sequences and random traffic.
module tb_div_sequencer;
    import div_pkg::*;

    localparam int N = 8;

`ifdef DIV_SEQ_DBZ_CHECK_EN
    localparam bit DBZ_ON = 1'b1;
`else
    localparam bit DBZ_ON = 1'b0;
`endif

    logic Clock  = 1'b0;
    logic Resetn = 1'b1;
    always #5 Clock = ~Clock;

    div_sequencer_if #(.N(N)) bus ();

    div_sequencer #(.N(N)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_results = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string what);
        n_tests++;
        n_fail++;
        $display("FAIL timeout_%s: bound expired, got 0 expected 1", what);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Behavioural core: latches on LA/EB, counts while s=1, holds Done until s drops.
    int           core_lat = 4;
    logic [N-1:0] c_a, c_b;
    int           c_cnt;

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            c_a <= '0; c_b <= '0; c_cnt <= 0;
            bus.div_done <= 1'b0; bus.div_q <= '0; bus.div_r <= '0;
        end else begin
            if (bus.div_la) c_a <= bus.div_a;
            if (bus.div_eb) c_b <= bus.div_b;
            if (!bus.div_s) begin
                c_cnt <= 0;
                bus.div_done <= 1'b0;
            end else if (!bus.div_done) begin
                c_cnt <= c_cnt + 1;
                if (c_cnt + 1 >= core_lat) begin
                    bus.div_done <= 1'b1;
                    bus.div_q <= (c_b == '0) ? '1  : c_a / c_b;
                    bus.div_r <= (c_b == '0) ? c_a : c_a % c_b;
                end
            end
        end
    end

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
    } res_t;

    function automatic res_t ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
        res_t e;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dbz = DBZ_ON;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        return e;
    endfunction

    res_t exp_q[$];

    // Monitor: scoreboard, protocol exclusions, and result stability while unconsumed.
    initial begin
        res_t         e;
        bit           prev_hold = 1'b0;
        logic [N-1:0] prev_q = '0, prev_r = '0;
        forever begin
            @(negedge Clock);
            if (!Resetn) begin
                prev_hold = 1'b0;
            end else begin
                if (bus.in_valid && bus.in_ready)
                    exp_q.push_back(ref_div(bus.in_a, bus.in_b));
                if (prev_hold) begin
                    check("hold_valid", 32'(bus.out_valid), 32'd1);
                    check("hold_q", 32'(bus.out_q), 32'(prev_q));
                    check("hold_r", 32'(bus.out_r), 32'(prev_r));
                end
                if (bus.out_valid && bus.out_ready && !bus.div_done) begin
                    n_results++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_q",   32'(bus.out_q),   32'(e.q));
                        check("sb_r",   32'(bus.out_r),   32'(e.r));
                        check("sb_dbz", 32'(bus.out_dbz), 32'(e.dbz));
                    end
                end
                if (bus.div_la)    check("la_s_overlap", 32'(bus.div_s), 32'd0);
                if (bus.out_valid) check("ready_valid_excl", 32'(bus.in_ready), 32'd0);
                prev_hold = bus.out_valid && !(bus.out_ready && !bus.div_done);
                prev_q = bus.out_q;
                prev_r = bus.out_r;
            end
        end
    end

    task automatic wait_ready();
        int i = 0;
        while (!bus.in_ready && i < 300) begin tick(); i++; end
        if (!bus.in_ready) timeout("in_ready");
    endtask

    task automatic wait_valid();
        int i = 0;
        while (!bus.out_valid && i < 300) begin tick(); i++; end
        if (!bus.out_valid) timeout("out_valid");
    endtask

    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output logic [N-1:0] q, output logic [N-1:0] r, output logic dbz);
        bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
        wait_ready();
        tick();
        bus.in_valid = 1'b0;
        wait_valid();
        q = bus.out_q; r = bus.out_r; dbz = bus.out_dbz;
        bus.out_ready = 1'b1;
        wait_ready();
    endtask

    typedef struct {
        logic [N-1:0] a, b, q, r;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [N-1:0] q, r;
        logic         dbz;
        int           r0, cyc;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2};
        vecs[1] = '{8'd5,   8'd9,   8'd0,   8'd5};
        vecs[2] = '{8'd255, 8'd1,   8'd255, 8'd0};
        vecs[3] = '{8'd9,   8'd3,   8'd3,   8'd0};
        vecs[4] = '{8'd0,   8'd5,   8'd0,   8'd0};
        vecs[5] = '{8'd200, 8'd200, 8'd1,   8'd0};

        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
        #1 Resetn = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_q",     32'(bus.out_q),     32'd0);
        check("rst_out_r",     32'(bus.out_r),     32'd0);
        check("rst_out_dbz",   32'(bus.out_dbz),   32'd0);
        check("rst_div_s",     32'(bus.div_s),     32'd0);
        check("rst_div_la",    32'(bus.div_la),    32'd0);
        check("rst_div_eb",    32'(bus.div_eb),    32'd0);
        check("rst_div_a",     32'(bus.div_a),     32'd0);
        check("rst_div_b",     32'(bus.div_b),     32'd0);
        Resetn = 1'b1;
        tick();

        // Cycle-accurate walk through one division: 100/7 with core latency 5.
        core_lat = 5;
        bus.in_a = 8'd100; bus.in_b = 8'd7; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("load_la",       32'(bus.div_la),   32'd1);
        check("load_eb",       32'(bus.div_eb),   32'd1);
        check("load_s",        32'(bus.div_s),    32'd0);
        check("load_div_a",    32'(bus.div_a),    32'd100);
        check("load_div_b",    32'(bus.div_b),    32'd7);
        check("load_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("run_s",  32'(bus.div_s),  32'd1);
        check("run_la", 32'(bus.div_la), 32'd0);
        cyc = 0;
        while (!bus.div_done && cyc < 100) begin tick(); cyc++; end
        if (!bus.div_done) timeout("div_done");
        check("valid_not_yet", 32'(bus.out_valid), 32'd0);
        tick();
        check("valid_rise", 32'(bus.out_valid), 32'd1);
        check("t_out_q",    32'(bus.out_q),     32'd14);
        check("t_out_r",    32'(bus.out_r),     32'd2);
        check("t_out_dbz",  32'(bus.out_dbz),   32'd0);
        check("result_s",   32'(bus.div_s),     32'd0);
        tick();
        check("held_while_done", 32'(bus.out_valid), 32'd1);
        tick();
        check("released_valid", 32'(bus.out_valid), 32'd0);
        check("released_ready", 32'(bus.in_ready),  32'd1);

        for (int i = 0; i < 6; i++) begin
            core_lat = int'($urandom_range(1, 2 * N + 2));
            run_div(vecs[i].a, vecs[i].b, q, r, dbz);
            check($sformatf("vec%0d_q", i), 32'(q),   32'(vecs[i].q));
            check($sformatf("vec%0d_r", i), 32'(r),   32'(vecs[i].r));
            check($sformatf("vec%0d_dbz", i), 32'(dbz), 32'd0);
        end

        // Backpressure: result must sit still; offered operands are ignored.
        core_lat = 7;
        bus.out_ready = 1'b0;
        r0 = n_results;
        bus.in_a = 8'd5; bus.in_b = 8'd9; bus.in_valid = 1'b1;
        wait_ready();
        tick();
        bus.in_a = 8'd1; bus.in_b = 8'd1;
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_valid",    32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready),  32'd0);
            check("bp_q",        32'(bus.out_q),     32'd0);
            check("bp_r",        32'(bus.out_r),     32'd5);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_ready();
        tick();
        check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
        check("bp_one_result", 32'(n_results - r0), 32'd1);

        // Back-to-back offers: three results in order.
        r0 = n_results;
        core_lat = 3;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin bus.in_a = 8'd200; bus.in_b = 8'd13;  end
                1: begin bus.in_a = 8'd17;  bus.in_b = 8'd4;   end
                default: begin bus.in_a = 8'd250; bus.in_b = 8'd250; end
            endcase
            wait_ready();
            tick();
        end
        bus.in_valid = 1'b0;
        cyc = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && cyc < 300) begin tick(); cyc++; end
        if (cyc >= 300) timeout("b2b_drain");
        check("b2b_count", 32'(n_results - r0), 32'd3);

        // Zero divisor.
        core_lat = 6;
        if (DBZ_ON) begin
            bus.in_a = 8'd42; bus.in_b = 8'd0; bus.in_valid = 1'b1;
            wait_ready();
            tick();
            bus.in_valid = 1'b0;
            check("dbz_valid", 32'(bus.out_valid), 32'd1);
            check("dbz_q",     32'(bus.out_q),     32'd255);
            check("dbz_r",     32'(bus.out_r),     32'd42);
            check("dbz_flag",  32'(bus.out_dbz),   32'd1);
            check("dbz_no_la", 32'(bus.div_la),    32'd0);
            check("dbz_no_s",  32'(bus.div_s),     32'd0);
            tick();
            check("dbz_done_valid", 32'(bus.out_valid), 32'd0);
            check("dbz_done_s",     32'(bus.div_s),     32'd0);
            run_div(8'd9, 8'd3, q, r, dbz);
            check("dbz_clear", 32'(dbz), 32'd0);
        end else begin
            run_div(8'd42, 8'd0, q, r, dbz);
            check("zero_b_q",   32'(q),   32'd255);
            check("zero_b_r",   32'(r),   32'd42);
            check("zero_b_dbz", 32'(dbz), 32'd0);
        end

        // Reset during RUN aborts without a result.
        core_lat = 12;
        r0 = n_results;
        bus.in_a = 8'd77; bus.in_b = 8'd3; bus.in_valid = 1'b1;
        wait_ready();
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check("pre_rst_s", 32'(bus.div_s), 32'd1);
        Resetn = 1'b0;
        #1;
        check("arst_in_ready",  32'(bus.in_ready),  32'd1);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_s",         32'(bus.div_s),     32'd0);
        check("arst_la",        32'(bus.div_la),    32'd0);
        check("arst_eb",        32'(bus.div_eb),    32'd0);
        check("arst_q",         32'(bus.out_q),     32'd0);
        check("arst_r",         32'(bus.out_r),     32'd0);
        check("arst_div_a",     32'(bus.div_a),     32'd0);
        exp_q.delete();
        tick();
        Resetn = 1'b1;
        repeat (3) tick();
        check("arst_no_result", 32'(n_results - r0), 32'd0);
        core_lat = 4;
        run_div(8'd9, 8'd3, q, r, dbz);
        check("post_rst_q", 32'(q), 32'd3);
        check("post_rst_r", 32'(r), 32'd0);

        // Random traffic against the reference model, with random backpressure.
        for (int k = 0; k < 40; k++) begin
            core_lat = int'($urandom_range(1, 2 * N + 2));
            bus.in_a = N'($urandom);
            bus.in_b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            bus.in_valid = 1'b1;
            wait_ready();
            tick();
            bus.in_valid = 1'b0;
            cyc = 0;
            while ((exp_q.size() != 0 || bus.out_valid) && cyc < 300) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                tick();
                cyc++;
            end
            if (cyc >= 300) timeout("rand_drain");
            bus.out_ready = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1, "watchdog");
    end

endmodule
